// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths and the return-owner encoding for the data-memory port arbiter.
// The return owner records which requester the next cycle's mem_rdata belongs to.
package dmem_port_arbiter_pkg;

    localparam int DBITS        = 32;
    localparam int DMEMADDRBITS = 16;
    localparam int DMEMWORDBITS = 2;
    localparam int MEMAW        = DMEMADDRBITS - DMEMWORDBITS;

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_CPU  = 2'd1,
        RET_AUX  = 2'd2
    } ret_state_e;

    function automatic logic [MEMAW-1:0] word_index(input logic [DBITS-1:0] addr);
        return addr[DMEMADDRBITS-1:DMEMWORDBITS];
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single synchronous-read dmem port between the cpu MEM stage and an aux requester.
// The cpu has priority; aux wins after MAXWAIT consecutive denied cycles.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAXWAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [DBITS-1:0] cpu_addr,
    input  logic [DBITS-1:0] cpu_wdata,
    output logic             cpu_stall,
    output logic [DBITS-1:0] cpu_rdata,
    output logic             cpu_rvalid,
    input  logic             aux_req,
    input  logic             aux_we,
    input  logic [DBITS-1:0] aux_addr,
    input  logic [DBITS-1:0] aux_wdata,
    output logic             aux_gnt,
    output logic [DBITS-1:0] aux_rdata,
    output logic             aux_rvalid,
    output logic             mem_en,
    output logic             mem_we,
    output logic [MEMAW-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);

    localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

    ret_state_e ret_q, ret_d;
    logic [3:0] wait_q, wait_d;

    logic active;
    logic cpu_eligible;
    logic aux_win;
    logic cpu_issue;

    // Every output is forced low while reset is high, including a pending return.
    assign active       = !reset;
    assign cpu_eligible = cpu_req && (ret_q != RET_CPU);
    assign aux_win      = aux_req && (!cpu_eligible || (wait_q >= MAXWAIT_C));
    assign cpu_issue    = cpu_eligible && !aux_win;

    assign aux_gnt    = active && aux_win;
    assign cpu_stall  = active && cpu_req && !(cpu_issue && cpu_we) && (ret_q != RET_CPU);
    assign cpu_rvalid = active && (ret_q == RET_CPU);
    assign aux_rvalid = active && (ret_q == RET_AUX);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign aux_rdata  = aux_rvalid ? mem_rdata : '0;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ret_d     = RET_NONE;
        wait_d    = wait_q;

        if (active && aux_win) begin
            mem_en    = 1'b1;
            mem_we    = aux_we;
            mem_addr  = word_index(aux_addr);
            mem_wdata = aux_we ? aux_wdata : '0;
            if (!aux_we) ret_d = RET_AUX;
        end else if (active && cpu_issue) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = word_index(cpu_addr);
            mem_wdata = cpu_we ? cpu_wdata : '0;
            if (!cpu_we) ret_d = RET_CPU;
        end

        if (!aux_req || aux_win) begin
            wait_d = '0;
        end else if (wait_q < MAXWAIT_C) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q  <= RET_NONE;
            wait_q <= '0;
        end else begin
            ret_q  <= ret_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural registered-read RAM and a read-return scoreboard.
// Expected read data comes from a reference memory updated as the bench drives writes.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req, cpu_we;
    logic [DBITS-1:0] cpu_addr, cpu_wdata;
    logic             cpu_stall, cpu_rvalid;
    logic [DBITS-1:0] cpu_rdata;
    logic             aux_req, aux_we;
    logic [DBITS-1:0] aux_addr, aux_wdata;
    logic             aux_gnt, aux_rvalid;
    logic [DBITS-1:0] aux_rdata;
    logic             mem_en, mem_we;
    logic [MEMAW-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MAXWAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (aux_gnt),
        .aux_rdata  (aux_rdata),
        .aux_rvalid (aux_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic [DBITS-1:0] ram [0:(1<<MEMAW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        bit               is_cpu;
        logic [DBITS-1:0] data;
        int               due;
    } exp_t;

    exp_t             sbq[$];
    logic [DBITS-1:0] ref_mem [int];
    int               cyc    = 0;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int widx(input logic [DBITS-1:0] a);
        return int'(a[DMEMADDRBITS-1:DMEMWORDBITS]);
    endfunction

    task automatic note_write(input logic [DBITS-1:0] a, input logic [DBITS-1:0] d);
        ref_mem[widx(a)] = d;
    endtask

    task automatic expect_read(input bit is_cpu, input logic [DBITS-1:0] a);
        exp_t e;
        e.is_cpu = is_cpu;
        e.data   = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : '0;
        e.due    = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic drive_cpu(input bit req, input bit we, input logic [DBITS-1:0] a, input logic [DBITS-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drive_aux(input bit req, input bit we, input logic [DBITS-1:0] a, input logic [DBITS-1:0] d);
        aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
    endtask

    // Let combinational outputs settle, then compare this cycle's read returns against the scoreboard.
    task automatic settle();
        bit               ecv = 1'b0;
        bit               eav = 1'b0;
        logic [DBITS-1:0] ed  = '0;
        #1;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            ecv = sbq[0].is_cpu;
            eav = !sbq[0].is_cpu;
            ed  = sbq[0].data;
            sbq.delete(0);
        end
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ecv));
        chk("aux_rvalid", 32'(aux_rvalid), 32'(eav));
        chk("cpu_rdata",  cpu_rdata, ecv ? ed : 32'h0);
        chk("aux_rdata",  aux_rdata, eav ? ed : 32'h0);
    endtask

    task automatic chk_port(input string tag, input bit en, input bit we,
                            input logic [MEMAW-1:0] a, input logic [DBITS-1:0] wd);
        chk({tag, ".mem_en"},    32'(mem_en),    32'(en));
        chk({tag, ".mem_we"},    32'(mem_we),    32'(we));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(a));
        chk({tag, ".mem_wdata"}, mem_wdata,      wd);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        drive_cpu(1, 0, 32'h100, 32'h0);
        drive_aux(1, 0, 32'h200, 32'h0);
        #1;

        // Reset: all outputs low even with both requesters active.
        settle();
        chk("rst.cpu_stall", 32'(cpu_stall), 0);
        chk("rst.aux_gnt",   32'(aux_gnt),   0);
        chk_port("rst", 0, 0, 14'h0, 32'h0);
        next_cycle();
        settle();
        next_cycle();
        reset = 1'b0;

        // Aux preload write, cpu idle.
        drive_cpu(0, 0, 32'h0, 32'h0);
        drive_aux(1, 1, 32'h200, 32'hA5A5_0200);
        settle();
        chk("pre.aux_gnt", 32'(aux_gnt), 1);
        chk_port("pre", 1, 1, 14'h080, 32'hA5A5_0200);
        note_write(32'h200, 32'hA5A5_0200);
        next_cycle();

        // Scenario 1: cpu store, no stall.
        drive_aux(0, 0, 32'h0, 32'h0);
        drive_cpu(1, 1, 32'h100, 32'hDEAD_BEEF);
        settle();
        chk("s1.cpu_stall", 32'(cpu_stall), 0);
        chk("s1.aux_gnt",   32'(aux_gnt),   0);
        chk_port("s1", 1, 1, 14'h040, 32'hDEAD_BEEF);
        note_write(32'h100, 32'hDEAD_BEEF);
        next_cycle();

        // Scenario 2: cpu load, one stall cycle, data next cycle.
        drive_cpu(1, 0, 32'h100, 32'h0);
        settle();
        chk("s2.issue.cpu_stall", 32'(cpu_stall), 1);
        chk_port("s2.issue", 1, 0, 14'h040, 32'h0);
        expect_read(1, 32'h100);
        next_cycle();
        settle();
        chk("s2.ret.cpu_stall", 32'(cpu_stall), 0);
        chk("s2.ret.mem_en",    32'(mem_en),    0);
        next_cycle();

        // Scenario 3: cpu stores every cycle, aux read starves until the wait limit.
        drive_aux(1, 0, 32'h200, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            logic [DBITS-1:0] a;
            a = (k % 2 == 1) ? 32'h300 : 32'h304;
            drive_cpu(1, 1, a, 32'(k));
            settle();
            if (k < 5) begin
                chk("s3.deny.aux_gnt",   32'(aux_gnt),   0);
                chk("s3.deny.cpu_stall", 32'(cpu_stall), 0);
                chk_port("s3.deny", 1, 1, MEMAW'(widx(a)), 32'(k));
                note_write(a, 32'(k));
            end else begin
                chk("s3.win.aux_gnt",   32'(aux_gnt),   1);
                chk("s3.win.cpu_stall", 32'(cpu_stall), 1);
                chk_port("s3.win", 1, 0, 14'h080, 32'h0);
                expect_read(0, 32'h200);
            end
            next_cycle();
        end
        drive_aux(0, 0, 32'h0, 32'h0);
        settle();
        chk("s3.retry.cpu_stall", 32'(cpu_stall), 0);
        chk_port("s3.retry", 1, 1, 14'h0C0, 32'd5);
        note_write(32'h300, 32'd5);
        next_cycle();

        // Scenario 4: aux write issues in the cpu load's return cycle.
        drive_cpu(1, 0, 32'h304, 32'h0);
        drive_aux(1, 1, 32'h204, 32'h5);
        settle();
        chk("s4.issue.cpu_stall", 32'(cpu_stall), 1);
        chk("s4.issue.aux_gnt",   32'(aux_gnt),   0);
        chk_port("s4.issue", 1, 0, 14'h0C1, 32'h0);
        expect_read(1, 32'h304);
        next_cycle();
        settle();
        chk("s4.ret.cpu_stall", 32'(cpu_stall), 0);
        chk("s4.ret.aux_gnt",   32'(aux_gnt),   1);
        chk_port("s4.ret", 1, 1, 14'h081, 32'h5);
        note_write(32'h204, 32'h5);
        next_cycle();
        drive_cpu(0, 0, 32'h0, 32'h0);
        drive_aux(1, 0, 32'h204, 32'h0);
        settle();
        chk("s4.rd.aux_gnt", 32'(aux_gnt), 1);
        chk_port("s4.rd", 1, 0, 14'h081, 32'h0);
        expect_read(0, 32'h204);
        next_cycle();
        drive_aux(0, 0, 32'h0, 32'h0);
        settle();
        chk("s4.idle.mem_en", 32'(mem_en), 0);
        next_cycle();

        // Scenario 5: reset in the return cycle discards the read; the load reissues afterwards.
        drive_cpu(1, 0, 32'h300, 32'h0);
        drive_aux(1, 0, 32'h204, 32'h0);
        settle();
        chk("s5.issue.cpu_stall", 32'(cpu_stall), 1);
        chk("s5.issue.aux_gnt",   32'(aux_gnt),   0);
        chk_port("s5.issue", 1, 0, 14'h0C0, 32'h0);
        next_cycle();
        reset = 1'b1;
        settle();
        chk("s5.rst.cpu_stall", 32'(cpu_stall), 0);
        chk("s5.rst.aux_gnt",   32'(aux_gnt),   0);
        chk_port("s5.rst", 0, 0, 14'h0, 32'h0);
        next_cycle();
        reset = 1'b0;
        settle();
        chk("s5.post.wait_cnt",  32'(dut.wait_q), 0);
        chk("s5.post.ret_state", 32'(dut.ret_q),  32'(RET_NONE));
        chk("s5.post.cpu_stall", 32'(cpu_stall),  1);
        chk("s5.post.aux_gnt",   32'(aux_gnt),    0);
        chk_port("s5.post", 1, 0, 14'h0C0, 32'h0);
        expect_read(1, 32'h300);
        next_cycle();
        settle();
        chk("s5.ret.cpu_stall", 32'(cpu_stall), 0);
        chk("s5.ret.aux_gnt",   32'(aux_gnt),   1);
        chk_port("s5.ret", 1, 0, 14'h081, 32'h0);
        expect_read(0, 32'h204);
        next_cycle();
        drive_cpu(0, 0, 32'h0, 32'h0);
        drive_aux(0, 0, 32'h0, 32'h0);
        settle();
        chk("s5.idle.mem_en", 32'(mem_en), 0);
        next_cycle();

        // Scenario 6: simultaneous cpu store and aux write with wait_cnt=0.
        drive_cpu(1, 1, 32'h308, 32'h66);
        drive_aux(1, 1, 32'h30C, 32'h77);
        settle();
        chk("s6.aux_gnt",   32'(aux_gnt),   0);
        chk("s6.cpu_stall", 32'(cpu_stall), 0);
        chk_port("s6", 1, 1, 14'h0C2, 32'h66);
        note_write(32'h308, 32'h66);
        next_cycle();
        drive_cpu(0, 0, 32'h0, 32'h0);
        settle();
        chk("s6.next.wait_cnt", 32'(dut.wait_q), 1);
        chk("s6.next.aux_gnt",  32'(aux_gnt),    1);
        chk_port("s6.next", 1, 1, 14'h0C3, 32'h77);
        note_write(32'h30C, 32'h77);
        next_cycle();
        drive_aux(0, 0, 32'h0, 32'h0);

        // Upper address bits are truncated; then read back the aux-written word.
        drive_cpu(1, 0, 32'h1234_0100, 32'h0);
        settle();
        chk_port("trunc", 1, 0, 14'h040, 32'h0);
        expect_read(1, 32'h1234_0100);
        next_cycle();
        settle();
        next_cycle();
        drive_cpu(1, 0, 32'h30C, 32'h0);
        settle();
        chk_port("rb", 1, 0, 14'h0C3, 32'h0);
        expect_read(1, 32'h30C);
        next_cycle();
        settle();
        next_cycle();
        drive_cpu(0, 0, 32'h0, 32'h0);
        settle();
        chk("end.sb_empty", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
